// File: rtl/a2d_sequencer_if.sv
// a2d_sequencer_if: SPI bus between the channel sequencer (master) and the ADC128S (slave).
interface a2d_sequencer_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_sequencer.sv
// a2d_sequencer: SPI master that round-robins three ADC128S channels. Each conversion is a
// command frame followed by a data frame carrying the same command word; the 12-bit result
// of the data frame is latched per slot and announced with a one-clk vld pulse.
// Optional build macro A2D_AVG_EN: four conversions per slot, result is their truncated mean.
module a2d_sequencer #(
  parameter logic [2:0]  CH_A  = 3'd0,
  parameter logic [2:0]  CH_B  = 3'd4,
  parameter logic [2:0]  CH_C  = 3'd5,
  parameter int unsigned DIV_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  a2d_sequencer_if.master spi,
  output logic [11:0]     res_a,
  output logic [11:0]     res_b,
  output logic [11:0]     res_c,
  output logic            vld,
  output logic [1:0]      slot
);

  localparam logic [DIV_W-1:0] DivOne   = DIV_W'(1);
  localparam logic [DIV_W-1:0] DivPre   = DIV_W'((1 << (DIV_W - 1)) + 7);
  localparam logic [DIV_W-1:0] DivSamp  = DIV_W'((1 << (DIV_W - 1)) + 1);
  // Decided one clk early so the register update lands as div reaches all-ones.
  localparam logic [DIV_W-1:0] DivShift = {DIV_W{1'b1}} - DivOne;
  localparam logic [4:0]       LastBit  = 5'd16;

  typedef enum logic [2:0] {StIdle, StCmd, StGap1, StData, StGap2} state_e;

  state_e           state_q, state_d;
  logic             ss_n_q, ss_n_d;
  logic             frame_start, frame_end, latch;
  logic [DIV_W-1:0] div_q;
  logic [4:0]       bit_cnt_q;
  logic [15:0]      tx_q;
  logic [11:0]      rx_q;
  logic             mosi_q;
  logic             gap_q;
  logic [1:0]       ptr_q;
  logic [2:0]       ch;
  logic [11:0]      res_a_q, res_b_q, res_c_q, res_new;
  logic             vld_q;
  logic [1:0]       slot_q;
  logic             conv_last, more_conv;

  assign frame_end = !ss_n_q && (div_q == DivShift) && (bit_cnt_q == LastBit);

  always_comb begin
    case (ptr_q)
      2'd0:    ch = CH_A;
      2'd1:    ch = CH_B;
      default: ch = CH_C;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state: a started conversion always runs both frames, en is only looked at when idle
  // or at the end of the trailing gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StCmd;
      StCmd:   if (frame_end) state_d = StGap1;
      StGap1:  if (gap_q) state_d = StData;
      StData:  if (frame_end) state_d = StGap2;
      StGap2:  if (gap_q) state_d = (en || more_conv) ? StCmd : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: SS_n is registered from the next state so it never glitches.
  always_comb begin
    ss_n_d      = !((state_d == StCmd) || (state_d == StData));
    frame_start = ss_n_q && !ss_n_d;
    latch       = (state_q == StData) && frame_end;
  end

  // Frame engine: SCLK divider, bit counter, command shifter and receive shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_n_q    <= 1'b1;
      div_q     <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      mosi_q    <= 1'b0;
      gap_q     <= 1'b0;
    end else begin
      ss_n_q <= ss_n_d;
      gap_q  <= ((state_q == StGap1) || (state_q == StGap2)) ? ~gap_q : 1'b0;
      if (frame_start) begin
        div_q     <= DivPre;
        bit_cnt_q <= '0;
        tx_q      <= {2'b00, ch, 11'h000};
      end else if (frame_end) begin
        // div is frozen here so SCLK stays high while SS_n rises.
        mosi_q <= 1'b0;
      end else if (!ss_n_q) begin
        div_q <= div_q + DivOne;
        if ((div_q == DivShift) && (bit_cnt_q != LastBit)) begin
          mosi_q <= tx_q[15];
          tx_q   <= {tx_q[14:0], 1'b0};
        end
        if ((div_q == DivSamp) && (bit_cnt_q != LastBit)) begin
          // Only the last 12 bits survive, so bits [15:12] drop out naturally.
          rx_q      <= {rx_q[10:0], spi.MISO};
          bit_cnt_q <= bit_cnt_q + 5'd1;
        end
      end
    end
  end

`ifdef A2D_AVG_EN
  logic [1:0]  avg_cnt_q;
  logic [13:0] acc_q, acc_sum;

  // The accumulator restarts on the first of each group of four conversions.
  assign acc_sum   = ((avg_cnt_q == 2'd0) ? 14'd0 : acc_q) + {2'b00, rx_q};
  assign res_new   = acc_sum[13:2];
  assign conv_last = (avg_cnt_q == 2'd3);
  assign more_conv = (avg_cnt_q != 2'd0);

  // Averaging state: conversion index within the slot and running sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avg_cnt_q <= '0;
      acc_q     <= '0;
    end else if (latch) begin
      avg_cnt_q <= avg_cnt_q + 2'd1;
      acc_q     <= acc_sum;
    end
  end
`else
  assign res_new   = rx_q;
  assign conv_last = 1'b1;
  assign more_conv = 1'b0;
`endif

  // Result registers, slot pointer and the vld pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      res_a_q <= '0;
      res_b_q <= '0;
      res_c_q <= '0;
      vld_q   <= 1'b0;
      slot_q  <= '0;
    end else begin
      vld_q <= 1'b0;
      if (latch && conv_last) begin
        vld_q  <= 1'b1;
        slot_q <= ptr_q;
        case (ptr_q)
          2'd0:    res_a_q <= res_new;
          2'd1:    res_b_q <= res_new;
          default: res_c_q <= res_new;
        endcase
        ptr_q <= (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
      end
    end
  end

  assign spi.SS_n = ss_n_q;
  assign spi.SCLK = ss_n_q | div_q[DIV_W-1];
  assign spi.MOSI = mosi_q;
  assign res_a    = res_a_q;
  assign res_b    = res_b_q;
  assign res_c    = res_c_q;
  assign vld      = vld_q;
  assign slot     = slot_q;

endmodule

// File: tb/tb_a2d_sequencer.sv
// tb_a2d_sequencer: randomized bench with an ADC128S-like slave and a slot/result reference model.
module tb_a2d_sequencer;
`ifdef A2D_AVG_EN
  localparam int Conv = 4;
`else
  localparam int Conv = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [11:0] res_a, res_b, res_c;
  logic        vld;
  logic [1:0]  slot;

  a2d_sequencer_if spi ();

  a2d_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .spi   (spi),
    .res_a (res_a),
    .res_b (res_b),
    .res_c (res_c),
    .vld   (vld),
    .slot  (slot)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int miso_mode = 0;  // 0: ADC ramp model, 1: MISO stuck high, 2: MISO stuck low

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ch_of(input int p);
    case (p)
      0:       return 3'd0;
      1:       return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  // ADC behaviour: k-th data frame returns 0xC00 - 16*k + channel.
  function automatic logic [11:0] adc_sample(input int k, input logic [2:0] c, input int mode);
    case (mode)
      1:       return 12'hFFF;
      2:       return 12'h000;
      default: return 12'(32'hC00 - k * 16 + int'(c));
    endcase
  endfunction

  function automatic logic [11:0] exp_result(input int k, input int p, input int mode);
    int sum = 0;
    for (int j = 0; j < Conv; j++) sum += int'(adc_sample(k + j, ch_of(p), mode));
    return 12'(sum / Conv);
  endfunction

  // Slave + monitor + reference model state (owned by the monitor process only).
  logic        prev_ss, prev_sclk;
  logic [15:0] word, mosi_sr, last_cmd;
  logic [2:0]  last_ch;
  logic [11:0] exp_res [3];
  logic [31:0] rnd;
  int falls, bit_i, low_run, bad_run, hi_run, par, n_data;
  int exp_ptr, exp_k, vld_cnt = 0, frame_cnt = 0, last_slot;

  always @(negedge clk) begin
    if (rst) begin
      prev_ss = 1'b1; prev_sclk = 1'b1; spi.MISO = 1'b0;
      par = 0; n_data = 0; last_ch = 3'd0; hi_run = 2;
      exp_ptr = 0; exp_k = 0;
      for (int i = 0; i < 3; i++) exp_res[i] = 12'h000;
    end else begin
      if (prev_ss && !spi.SS_n) begin
        check("ss_gap_ge2", 32'(hi_run >= 2), 32'd1);
        rnd = $urandom;
        word[11:0]  = adc_sample(n_data, last_ch, miso_mode);
        word[15:12] = (miso_mode == 1) ? 4'hF : (miso_mode == 2) ? 4'h0 : rnd[3:0];
        falls = 0; bit_i = 0; mosi_sr = '0; low_run = 0; bad_run = 0;
      end
      if (!spi.SS_n) begin
        if (prev_sclk && !spi.SCLK) begin
          falls++;
          if (bit_i < 16) spi.MISO = word[15 - bit_i];
          bit_i++;
        end
        if (!prev_sclk && spi.SCLK) begin
          mosi_sr = {mosi_sr[14:0], spi.MOSI};
          if (low_run != 16) bad_run++;
          low_run = 0;
        end
        if (!spi.SCLK) low_run++;
      end
      if (!prev_ss && spi.SS_n) begin
        check("frame_falls", falls, 16);
        check("frame_sclk_low16", bad_run, 0);
        check("frame_cmd", mosi_sr, {2'b00, ch_of(exp_ptr), 11'h000});
        last_cmd = mosi_sr;
        last_ch  = mosi_sr[13:11];
        frame_cnt++;
        if (par == 1) n_data++;
        par = 1 - par;
        hi_run = 0;
        spi.MISO = 1'b0;
      end
      if (spi.SS_n) hi_run++;
      if (vld) begin
        check("vld_slot", slot, exp_ptr);
        exp_res[exp_ptr] = exp_result(exp_k, exp_ptr, miso_mode);
        check("res_a", res_a, exp_res[0]);
        check("res_b", res_b, exp_res[1]);
        check("res_c", res_c, exp_res[2]);
        last_slot = int'(slot);
        exp_ptr = (exp_ptr + 1) % 3;
        exp_k += Conv;
        vld_cnt++;
      end
      prev_ss = spi.SS_n; prev_sclk = spi.SCLK;
    end
  end

  task automatic wait_vlds(input int n);
    int target = vld_cnt + n;
    int c = 0;
    while (vld_cnt < target && c < n * 1300 * Conv + 500) begin
      @(negedge clk);
      c++;
    end
    check("vld_timeout", 32'(vld_cnt >= target), 32'd1);
  endtask

  task automatic wait_ss_low();
    int c = 0;
    while (spi.SS_n && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("ss_fall_timeout", 32'(spi.SS_n), 32'd0);
  endtask

  // Run n slot results in the given MISO mode, dropping en during the last one.
  task automatic run_convs(input int n, input int mode);
    @(negedge clk);
    miso_mode = mode;
    en = 1'b1;
    repeat (3) @(negedge clk);
    if (n > 1) wait_vlds(n - 1);
    repeat ($urandom_range(3, 300)) @(negedge clk);
    en = 1'b0;
    wait_vlds(1);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int f0, c;
    repeat (3) @(negedge clk);
    check("rst_ss_n", spi.SS_n, 1);
    check("rst_sclk", spi.SCLK, 1);
    check("rst_mosi", spi.MOSI, 0);
    check("rst_res_a", res_a, 0);
    check("rst_res_b", res_b, 0);
    check("rst_res_c", res_c, 0);
    check("rst_vld", vld, 0);
    check("rst_slot", slot, 0);
    rst = 1'b0;

    // Slots A, B, C, A from the ramp model.
    run_convs(4, 0);

    // Drop en inside the slot-B command frame.
    en = 1'b1;
    wait_ss_low();
    repeat ($urandom_range(5, 400)) @(negedge clk);
    en = 1'b0;
    wait_vlds(1);
    check("drop_slot", last_slot, 1);
    f0 = frame_cnt;
    repeat (2000) @(negedge clk);
    check("idle_no_frames", frame_cnt, f0);
    check("idle_ss_n", spi.SS_n, 1);
    en = 1'b1;
    c = 0;
    while (frame_cnt == f0 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("resume_ch", {29'd0, last_cmd[13:11]}, 5);
    en = 1'b0;
    wait_vlds(1);
    repeat (6) @(negedge clk);

    run_convs(1, 1);
    run_convs(1, 2);
    for (int i = 0; i < 3; i++) run_convs(1, $urandom_range(0, 2));

    // Asynchronous reset in the middle of a frame.
    miso_mode = 0;
    en = 1'b1;
    wait_ss_low();
    repeat ($urandom_range(20, 400)) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_ss_n", spi.SS_n, 1);
    check("rst_mid_sclk", spi.SCLK, 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_vld", vld, 0);
    end
    check("rst_mid_res_a", res_a, 0);
    check("rst_mid_res_b", res_b, 0);
    check("rst_mid_res_c", res_c, 0);
    rst = 1'b0;
    run_convs(1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end
endmodule
